// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory-op arbiter: op field slices, widths, state encodings.
package mem_arb_pkg;

  localparam int unsigned OP_W      = 40;
  localparam int unsigned WD_W      = 128;
  localparam int unsigned DEST_HI   = 39;
  localparam int unsigned DEST_LO   = 36;
  localparam int unsigned TYPE_HI   = 35;
  localparam int unsigned TYPE_LO   = 32;
  localparam int unsigned DATA_HI   = 31;
  localparam int unsigned DATA_LO   = 0;
  localparam int unsigned FLUSH_BIT = 28;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_XFER_W0 = 2'd1,
    ARB_XFER_W1 = 2'd2
  } arb_state_e;

  // A flush carries two write beats; dest 0 (display) never does.
  function automatic logic is_flush(input logic [OP_W-1:0] op);
    return (op[FLUSH_BIT] == 1'b0) && (op[DEST_HI:DEST_LO] != 4'd0);
  endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Free-running grant/stall counters for the memory-op arbiter (wrap at 2^32).
module mem_arb_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        resend_grant_i,
  input  logic        fresh_grant_i,
  input  logic        stall_i,
  output logic [31:0] stat_resend_o,
  output logic [31:0] stat_fresh_o,
  output logic [31:0] stat_stall_o
);

  logic [31:0] resend_q, resend_d;
  logic [31:0] fresh_q, fresh_d;
  logic [31:0] stall_q, stall_d;

  // Next-state: increment each counter on its event.
  always_comb begin
    resend_d = resend_q + {31'd0, resend_grant_i};
    fresh_d  = fresh_q + {31'd0, fresh_grant_i};
    stall_d  = stall_q + {31'd0, stall_i};
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resend_q <= '0;
      fresh_q  <= '0;
      stall_q  <= '0;
    end else begin
      resend_q <= resend_d;
      fresh_q  <= fresh_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_resend_o = resend_q;
  assign stat_fresh_o  = fresh_q;
  assign stat_stall_o  = stall_q;

endmodule

// File: rtl/mem_op_arbiter.sv
// Arbitrates resend and fresh op queues into the memory-controller op queue. Resends have
// priority up to a run limit; a fresh flush is followed atomically by its two write beats.
// Optional statistics counters are enabled by defining ARB_STATS_EN.
module mem_op_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_RESEND_RUN = 4,
  parameter int unsigned RUN_W          = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              resendQempty,
  output logic              rdResend,
  input  logic [OP_W-1:0]   resendIn,
  input  logic              reqQempty,
  output logic              rdReq,
  input  logic [OP_W-1:0]   reqIn,
  input  logic              reqWDempty,
  output logic              rdReqWD,
  input  logic [WD_W-1:0]   reqWDIn,
  input  logic              memOpQfull,
  output logic              wrMemOp,
  output logic [OP_W-1:0]   memOpOut,
  input  logic              writeDataQfull,
  output logic              wrWriteData,
  output logic [WD_W-1:0]   writeDataOut
`ifdef ARB_STATS_EN
  ,
  output logic [31:0]       statResend,
  output logic [31:0]       statFresh,
  output logic [31:0]       statStall
`endif
);

  localparam logic [RUN_W-1:0] RunMax = RUN_W'(MAX_RESEND_RUN);

  arb_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             grant_resend, grant_fresh, move_beat;

  // Grant decision and next state; run counts consecutive resend grants.
  always_comb begin
    grant_resend = 1'b0;
    grant_fresh  = 1'b0;
    move_beat    = 1'b0;
    state_d      = state_q;
    run_d        = run_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (!memOpQfull) begin
          if (!resendQempty && (reqQempty || (run_q < RunMax))) begin
            grant_resend = 1'b1;
          end else if (!reqQempty) begin
            grant_fresh = 1'b1;
          end
        end
        if (grant_resend) begin
          run_d = (run_q == RunMax) ? run_q : run_q + 1'b1;
        end else if (grant_fresh || resendQempty) begin
          run_d = '0;
        end
        if (grant_fresh && is_flush(reqIn)) begin
          state_d = ARB_XFER_W0;
        end
      end
      ARB_XFER_W0: begin
        if (!reqWDempty && !writeDataQfull) begin
          move_beat = 1'b1;
          state_d   = ARB_XFER_W1;
        end
      end
      ARB_XFER_W1: begin
        if (!reqWDempty && !writeDataQfull) begin
          move_beat = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // State and run-counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Strobes are held low while reset is asserted, even though the flags may be live.
  assign rdResend     = grant_resend & ~reset;
  assign rdReq        = grant_fresh & ~reset;
  assign wrMemOp      = (grant_resend | grant_fresh) & ~reset;
  assign rdReqWD      = move_beat & ~reset;
  assign wrWriteData  = move_beat & ~reset;
  assign memOpOut     = reset        ? '0       :
                        grant_resend ? resendIn :
                        grant_fresh  ? reqIn    : '0;
  assign writeDataOut = reset ? '0 : reqWDIn;

`ifdef ARB_STATS_EN
  logic pending, stall;

  // Stall: something is waiting but nothing moved this cycle.
  always_comb begin
    pending = !resendQempty || !reqQempty || ((state_q != ARB_IDLE) && !reqWDempty);
    stall   = pending && !wrMemOp && !wrWriteData && !reset;
  end

  mem_arb_stats u_stats (
    .clk_i          (clock),
    .rst_i          (reset),
    .resend_grant_i (rdResend),
    .fresh_grant_i  (rdReq),
    .stall_i        (stall),
    .stat_resend_o  (statResend),
    .stat_fresh_o   (statFresh),
    .stat_stall_o   (statStall)
  );
`endif

endmodule

// File: tb/tb_mem_op_arbiter.sv
// Scoreboard bench for mem_op_arbiter: bench-side FWFT queues feed the DUT, stimulus pushes
// expected outputs (value + cycle) and a monitor compares every push the DUT makes.
module tb_mem_op_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         resendQempty, reqQempty, reqWDempty;
  logic         memOpQfull, writeDataQfull;
  logic [39:0]  resendIn, reqIn;
  logic [127:0] reqWDIn;
  logic         rdResend, rdReq, rdReqWD, wrMemOp, wrWriteData;
  logic [39:0]  memOpOut;
  logic [127:0] writeDataOut;
`ifdef ARB_STATS_EN
  logic [31:0]  statResend, statFresh, statStall;
`endif

  always #5 clock = ~clock;

  mem_op_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .resendQempty   (resendQempty),
    .rdResend       (rdResend),
    .resendIn       (resendIn),
    .reqQempty      (reqQempty),
    .rdReq          (rdReq),
    .reqIn          (reqIn),
    .reqWDempty     (reqWDempty),
    .rdReqWD        (rdReqWD),
    .reqWDIn        (reqWDIn),
    .memOpQfull     (memOpQfull),
    .wrMemOp        (wrMemOp),
    .memOpOut       (memOpOut),
    .writeDataQfull (writeDataQfull),
    .wrWriteData    (wrWriteData),
    .writeDataOut   (writeDataOut)
`ifdef ARB_STATS_EN
    ,
    .statResend     (statResend),
    .statFresh      (statFresh),
    .statStall      (statStall)
`endif
  );

  typedef struct {
    logic         is_beat;
    logic [127:0] val;
    int           t;
  } exp_t;

  exp_t         exp_q[$];
  logic [39:0]  rq[$];
  logic [39:0]  fq[$];
  logic [127:0] wdq[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [39:0] mk(input logic [3:0] d, input logic [3:0] ty,
                                     input logic [31:0] data);
    return {d, ty, data};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic b, input logic [127:0] v, input int t);
    exp_t e;
    e.is_beat = b;
    e.val     = v;
    e.t       = t;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clock);
      n++;
    end
    #1;
    check({"drain_", name}, 128'(exp_q.size()), 128'd0);
    exp_q.delete();
    tick(2);
  endtask

  task automatic check_out(input logic b, input logic [127:0] v);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s: got %0h at cycle %0d, want no push", b ? "beat" : "op", v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_beat !== b || e.val !== v || e.t != cyc) begin
        bad++;
        $display("FAIL push: got beat=%0b val=%0h cyc=%0d want beat=%0b val=%0h cyc=%0d",
                 b, v, cyc, e.is_beat, e.val, e.t);
      end
    end
  endtask

  // Monitor: sample just before each rising edge and compare against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      #4;
      total++;
      if (((rdResend | rdReq) !== wrMemOp) || (rdReqWD !== wrWriteData) ||
          (rdResend & rdReq)) begin
        bad++;
        $display("FAIL pairing: rdR=%0b rdF=%0b wrOp=%0b rdWD=%0b wrWD=%0b", rdResend, rdReq,
                 wrMemOp, rdReqWD, wrWriteData);
      end
      if (wrMemOp) begin
        check("push_when_full", memOpQfull, 1'b0);
        check_out(1'b0, {88'd0, memOpOut});
      end
      if (wrWriteData) check_out(1'b1, writeDataOut);
    end
  end

  // Feeder: model the upstream FWFT queues, popping on the strobes seen before the edge.
  initial begin
    logic s_r, s_f, s_w;
    resendQempty = 1'b1;
    reqQempty    = 1'b1;
    reqWDempty   = 1'b1;
    resendIn     = '0;
    reqIn        = '0;
    reqWDIn      = '0;
    forever begin
      @(negedge clock);
      #4;
      s_r = rdResend;
      s_f = rdReq;
      s_w = rdReqWD;
      @(posedge clock);
      #1;
      if (s_r) begin
        check("pop_resend_nonempty", 128'(rq.size() != 0), 128'd1);
        if (rq.size() != 0) void'(rq.pop_front());
      end
      if (s_f) begin
        check("pop_fresh_nonempty", 128'(fq.size() != 0), 128'd1);
        if (fq.size() != 0) void'(fq.pop_front());
      end
      if (s_w) begin
        check("pop_wd_nonempty", 128'(wdq.size() != 0), 128'd1);
        if (wdq.size() != 0) void'(wdq.pop_front());
      end
      #1;
      resendQempty = (rq.size() == 0);
      reqQempty    = (fq.size() == 0);
      reqWDempty   = (wdq.size() == 0);
      resendIn     = (rq.size() != 0) ? rq[0] : '0;
      reqIn        = (fq.size() != 0) ? fq[0] : '0;
      reqWDIn      = (wdq.size() != 0) ? wdq[0] : '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    int k;
    logic [39:0]  r_init, fl, fl2, x0, d0, f1, fr;
    logic [127:0] wa, wb, wc, w_init;
    r_init = mk(4'h1, 4'h2, 32'h1000_00AA);
    w_init = 128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444;
    memOpQfull     = 1'b0;
    writeDataQfull = 1'b0;

    // Reset: strobes and data outputs held at zero although inputs are live.
    rq.push_back(r_init);
    wdq.push_back(w_init);
    tick(2);
    check("rst_rdResend", rdResend, 1'b0);
    check("rst_wrMemOp", wrMemOp, 1'b0);
    check("rst_rdReqWD", rdReqWD, 1'b0);
    check("rst_memOpOut", memOpOut, 40'd0);
    check("rst_writeDataOut", writeDataOut, 128'd0);
`ifdef ARB_STATS_EN
    check("rst_stats", {statResend, statFresh, statStall}, 96'd0);
`endif
    reset = 1'b0;
    wdq.delete();
    push_exp(1'b0, r_init, cyc);
    drain("reset_release");

    // Test 1: resend-only run, then fresh arrives once the run counter is saturated.
    k  = cyc;
    fr = mk(4'h3, 4'h1, 32'h1000_0F00);
    for (int i = 0; i < 9; i++) rq.push_back(mk(4'h1, 4'h2, 32'h1000_0100 + i));
    for (int i = 0; i < 8; i++) push_exp(1'b0, mk(4'h1, 4'h2, 32'h1000_0100 + i), k + i);
    push_exp(1'b0, fr, k + 8);
    push_exp(1'b0, mk(4'h1, 4'h2, 32'h1000_0108), k + 9);
    tick(8);
    fq.push_back(fr);
    drain("resend_run");

    // Test 2: both ready, fresh wins after every four resends.
    k = cyc;
    for (int i = 0; i < 8; i++) rq.push_back(mk(4'h1, 4'h4, 32'h1000_0200 + i));
    for (int i = 0; i < 2; i++) fq.push_back(mk(4'h3, 4'h1, 32'h1000_0300 + i));
    for (int i = 0; i < 4; i++) push_exp(1'b0, mk(4'h1, 4'h4, 32'h1000_0200 + i), k + i);
    push_exp(1'b0, mk(4'h3, 4'h1, 32'h1000_0300), k + 4);
    for (int i = 4; i < 8; i++) push_exp(1'b0, mk(4'h1, 4'h4, 32'h1000_0200 + i), k + i + 1);
    push_exp(1'b0, mk(4'h3, 4'h1, 32'h1000_0301), k + 9);
    drain("fairness");

    // Test 3: flush moves atomically with beats; downstream data full for three cycles.
    k  = cyc;
    fl = mk(4'h2, 4'h1, 32'h0000_0ABC);
    wa = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    wb = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    fq.push_back(fl);
    wdq.push_back(wa);
    wdq.push_back(wb);
    writeDataQfull = 1'b1;
    push_exp(1'b0, fl, k);
    push_exp(1'b1, wa, k + 3);
    push_exp(1'b1, wb, k + 4);
    push_exp(1'b0, mk(4'h1, 4'h2, 32'h1000_0333), k + 5);
    tick(1);
    rq.push_back(mk(4'h1, 4'h2, 32'h1000_0333));
    tick(2);
    writeDataQfull = 1'b0;
    drain("flush_atomic");

    // Test 4: op queue full stalls both sides and keeps the run count.
    k = cyc;
    for (int i = 0; i < 6; i++) rq.push_back(mk(4'h1, 4'h5, 32'h1000_0400 + i));
    fq.push_back(mk(4'h3, 4'h5, 32'h1000_0500));
    for (int i = 0; i < 3; i++) push_exp(1'b0, mk(4'h1, 4'h5, 32'h1000_0400 + i), k + i);
    push_exp(1'b0, mk(4'h1, 4'h5, 32'h1000_0403), k + 8);
    push_exp(1'b0, mk(4'h3, 4'h5, 32'h1000_0500), k + 9);
    push_exp(1'b0, mk(4'h1, 4'h5, 32'h1000_0404), k + 10);
    push_exp(1'b0, mk(4'h1, 4'h5, 32'h1000_0405), k + 11);
    tick(3);
    memOpQfull = 1'b1;
    #3;
    check("full_no_pop", {rdResend, rdReq, wrMemOp}, 3'b000);
    tick(5);
    memOpQfull = 1'b0;
    drain("op_full");

    // Test 5: flush-looking resend and dest-0 fresh op never pull beats.
    k  = cyc;
    x0 = mk(4'h5, 4'h0, 32'h0000_0000);
    d0 = mk(4'h0, 4'h3, 32'h0000_0055);
    f1 = mk(4'h3, 4'h1, 32'h1000_0077);
    wc = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    rq.push_back(x0);
    rq.push_back(mk(4'h1, 4'h2, 32'h1000_0666));
    fq.push_back(d0);
    fq.push_back(f1);
    wdq.push_back(wc);
    push_exp(1'b0, x0, k);
    push_exp(1'b0, mk(4'h1, 4'h2, 32'h1000_0666), k + 1);
    push_exp(1'b0, d0, k + 2);
    push_exp(1'b0, f1, k + 3);
    drain("non_flush");
    check("non_flush_beat_kept", 128'(wdq.size()), 128'd1);
    wdq.delete();
    tick(2);

    // Test 6: reset while waiting in the second beat state.
    k   = cyc;
    fl2 = mk(4'h4, 4'h1, 32'h0000_0111);
    wa  = 128'h1234_5678_0000_0000_0000_0000_0000_00A2;
    wb  = 128'h8765_4321_0000_0000_0000_0000_0000_00B2;
    fq.push_back(fl2);
    wdq.push_back(wa);
    push_exp(1'b0, fl2, k);
    push_exp(1'b1, wa, k + 1);
    tick(3);
    rq.push_back(mk(4'h1, 4'h2, 32'h1000_0777));
    wdq.push_back(wb);
    reset = 1'b1;
    #3;
    check("rst_xfer_strobes", {rdResend, rdReq, rdReqWD, wrMemOp, wrWriteData}, 5'b00000);
    check("rst_xfer_memOpOut", memOpOut, 40'd0);
    check("rst_xfer_writeDataOut", writeDataOut, 128'd0);
`ifdef ARB_STATS_EN
    tick(1);
    check("rst_xfer_stats", {statResend, statFresh, statStall}, 96'd0);
`else
    tick(1);
`endif
    reset = 1'b0;
    push_exp(1'b0, mk(4'h1, 4'h2, 32'h1000_0777), cyc);
    drain("reset_xfer");
    check("reset_xfer_beat_kept", 128'(wdq.size()), 128'd1);
    wdq.delete();
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
